display_formatter: RTL and testbench
====================================

// Module: display_formatter
// PURPOSE
//   Converts a signed binary result from the calculator datapath into four
//   7-segment patterns oct0..oct3 for the 4-digit output scanner. Conversion is
//   iterative (double-dabble): one shift per clock, with a Load/Busy/Done
//   handshake. Applies leading-zero blanking, minus sign and " Err" on overflow.
//   The displayed patterns hold steady during conversion; the scanner never
//   sees partial data.
// PARAMETERS
//   WIDTH    16  width of Value, two's complement; legal range 8..16
//   BLANK_LZ 1   1 = blank leading zeros; 0 = show them (sign then sits in oct0)
// PORTS
//   Clock  in   1      system clock, all state on posedge
//   Reset  in   1      asynchronous, active-low; clears all state immediately
//   Value  in   WIDTH  signed number to display; sampled only with Load
//   Load   in   1      request; accepted only when Busy=0
//   Busy   out  1      conversion in progress; Load ignored while high
//   Done   out  1      one-cycle pulse; oct0..oct3 updated on the same edge
//   oct0   out  [0:7]  leftmost digit pattern (scanner SD=1000)
//   oct1   out  [0:7]  second digit
//   oct2   out  [0:7]  third digit
//   oct3   out  [0:7]  rightmost (units) digit
// BEHAVIOUR
//   Segment bit order in every [0:7] pattern: a,b,c,d,e,f,g,dp; 1 = lit.
//   Codes: 0=11111100 1=01100000 2=11011010 3=11110010 4=01100110
//          5=10110110 6=10111110 7=11100000 8=11111110 9=11110110
//          '-'=00000010 'E'=10011110 'r'=00001010 blank=00000000; dp always 0.
//   Reset (Reset=0): state IDLE; Busy=0, Done=0, oct0..oct3=blank.
//   FSM IDLE -> CONV -> FMT -> IDLE.
//   - IDLE: on the edge where Load=1 -> capture neg=Value[WIDTH-1],
//     mag=|Value| as WIDTH-bit unsigned (most-negative value gives 2^(WIDTH-1),
//     no wrap); clear BCD; go to CONV; Busy=1 from that edge on.
//   - CONV: exactly WIDTH edges; each edge adds 3 to every BCD nibble >=5,
//     then shifts {bcd,mag} left 1. BCD is 5 nibbles (20 bits).
//   - FMT: one edge; writes oct0..oct3, Done=1, Busy=0; back to IDLE.
//   Latency: Load sampled at edge N -> outputs and Done change at edge
//   N+WIDTH+1. Busy is high for edges N+1..N+WIDTH. Load at N+WIDTH+1 accepted.
//   Formatting (in FMT):
//   - overflow = (!neg && mag>9999) || (neg && mag>999) -> blank,E,r,r
//   - else the 4 low BCD digits go right-aligned; oct3 always shows a digit.
//     With BLANK_LZ=1, leading zeros are blank. If neg, '-' goes in the blank
//     position directly left of the leading nonzero digit.
//     With BLANK_LZ=0, neg forces oct0='-'; the range check is unchanged.
//   - zero is never negative (Value=0 -> neg=0).
//   Load while Busy: ignored, no queueing. Load held high: re-accepted in IDLE.
//   Reset mid-conversion: immediate IDLE and blank; no Done pulse.
//   Value changes after Load have no effect on the conversion in progress.
// STRUCTURE
//   Shared include seg_codes.vh: segment code localparams (SEG_0..SEG_9,
//   SEG_MINUS, SEG_E, SEG_R, SEG_BLANK) and FSM state encodings. The output
//   scanner and key echo logic reuse it.
//   Sub-module bin2bcd_seq: WIDTH-cycle double-dabble core with Start/Done,
//   same Clock/Reset. display_formatter keeps the FSM, sign/abs and
//   formatting logic.
// TESTING
//   T1 reset: Reset=0 mid-CONV (Load 1234, assert at edge N+5) -> Busy=0,
//      oct*=00000000 immediately; no Done.
//   T2 Load Value=1234 -> Done at edge N+17; oct0..3 = 1,2,3,4 codes;
//      Busy high for exactly 16 cycles.
//   T3 Value=-5 -> blank,blank,'-',5; Value=0 -> blank,blank,blank,0;
//      Value=-999 -> '-',9,9,9.
//   T4 Value=10000 -> blank,E,r,r; Value=-1000 -> blank,E,r,r;
//      Value=-32768 -> blank,E,r,r, with no wrap to a positive value.
//   T5 Load 42, then Load 77 at edge N+3 (Busy) -> 77 ignored; display
//      shows blank,blank,4,2; old patterns held stable until edge N+17.
//   T6 Load held high continuously, Value=9999 -> Done every 17 cycles;
//      display 9,9,9,9 constant. With BLANK_LZ=0, Value=-7 -> '-',0,0,7.

Source files
------------

// File: rtl/display_formatter_pkg.sv
// display_formatter_pkg
//   Shared definitions for the display formatter slice: 7-segment codes in
//   a,b,c,d,e,f,g,dp order (bit 0 = segment a, 1 = lit), the formatter FSM
//   state type, and helpers for digit encoding and the double-dabble step.
//   No ports; imported by the interface users and the modules of this slice.
package display_formatter_pkg;

    localparam logic [0:7] SEG_0     = 8'b11111100;
    localparam logic [0:7] SEG_1     = 8'b01100000;
    localparam logic [0:7] SEG_2     = 8'b11011010;
    localparam logic [0:7] SEG_3     = 8'b11110010;
    localparam logic [0:7] SEG_4     = 8'b01100110;
    localparam logic [0:7] SEG_5     = 8'b10110110;
    localparam logic [0:7] SEG_6     = 8'b10111110;
    localparam logic [0:7] SEG_7     = 8'b11100000;
    localparam logic [0:7] SEG_8     = 8'b11111110;
    localparam logic [0:7] SEG_9     = 8'b11110110;
    localparam logic [0:7] SEG_MINUS = 8'b00000010;
    localparam logic [0:7] SEG_E     = 8'b10011110;
    localparam logic [0:7] SEG_R     = 8'b00001010;
    localparam logic [0:7] SEG_BLANK = 8'b00000000;

    // Five BCD nibbles cover the largest magnitude, 2^15 = 32768.
    localparam int BCD_BITS = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FMT  = 2'd2
    } FormatterState;

    // Map one BCD digit to its segment pattern; non-decimal codes go blank.
    function automatic logic [0:7] segOf(input logic [3:0] digit);
        logic [0:7] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Double-dabble correction: any nibble of 5 or more gets 3 added so the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [BCD_BITS-1:0] dabbleAdjust(input logic [BCD_BITS-1:0] bcd);
        logic [BCD_BITS-1:0] adj;
        adj = bcd;
        for (int i = 0; i < BCD_BITS / 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/display_formatter_if.sv
// display_formatter_if
//   Bundles the request/response and display signals of the formatter.
//   Value  : signed number to display (sampled only with Load)
//   Load   : conversion request
//   Busy   : conversion in progress
//   Done   : one-cycle pulse when oct0..oct3 update
//   oct0..oct3 : segment patterns, oct0 leftmost, oct3 units
//   master = requester / scanner side, slave = formatter side.
interface display_formatter_if #(parameter int WIDTH = 16);

    logic [WIDTH-1:0] Value;
    logic             Load;
    logic             Busy;
    logic             Done;
    logic [0:7]       oct0;
    logic [0:7]       oct1;
    logic [0:7]       oct2;
    logic [0:7]       oct3;

    modport master (
        output Value, Load,
        input  Busy, Done, oct0, oct1, oct2, oct3
    );

    modport slave (
        input  Value, Load,
        output Busy, Done, oct0, oct1, oct2, oct3
    );

endinterface

// File: rtl/display_formatter_bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential binary-to-BCD converter, one double-dabble shift per clock.
//   Clock : system clock
//   Reset : asynchronous, active-low
//   Start : load Mag and clear the BCD accumulator on this edge
//   Mag   : unsigned magnitude, WIDTH bits
//   Done  : high during the cycle whose closing edge performs the last shift
//   Bcd   : five-digit BCD result, valid after Done's edge, held until Start
module bin2bcd_seq
    import display_formatter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic [WIDTH-1:0]    Mag,
    output logic                Done,
    output logic [BCD_BITS-1:0] Bcd
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [BCD_BITS-1:0] bcdReg;
    logic [WIDTH-1:0]    magReg;
    logic [CNT_W-1:0]    shiftCount;
    logic                running;
    logic [BCD_BITS-1:0] bcdAdjusted;

    // The correction is applied to the current BCD value and the shift happens
    // on the same edge, so each edge performs one complete dabble step.
    always_comb begin
        bcdAdjusted = dabbleAdjust(bcdReg);
    end

    // Start wins over an ongoing run so a new load always begins cleanly.
    // Each running edge shifts {bcd, mag} left by one; after WIDTH shifts the
    // core stops and leaves the result in place for the formatter to read.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            bcdReg     <= '0;
            magReg     <= '0;
            shiftCount <= '0;
            running    <= 1'b0;
        end else if (Start) begin
            bcdReg     <= '0;
            magReg     <= Mag;
            shiftCount <= '0;
            running    <= 1'b1;
        end else if (running) begin
            bcdReg     <= {bcdAdjusted[BCD_BITS-2:0], magReg[WIDTH-1]};
            magReg     <= {magReg[WIDTH-2:0], 1'b0};
            shiftCount <= shiftCount + CNT_W'(1);
            if (shiftCount == CNT_W'(WIDTH - 1)) begin
                running <= 1'b0;
            end
        end
    end

    // Done flags the final shift cycle so the owner can leave its conversion
    // state on the very edge that completes the result.
    assign Done = running && (shiftCount == CNT_W'(WIDTH - 1));
    assign Bcd  = bcdReg;

endmodule

// File: rtl/display_formatter.sv
// display_formatter
//   Converts a signed WIDTH-bit value into four 7-segment patterns with
//   leading-zero blanking, a minus sign, and " Err" on overflow.
//   Clock : system clock
//   Reset : asynchronous, active-low; blanks the display and aborts conversion
//   bus   : display_formatter_if slave (Value, Load, Busy, Done, oct0..oct3)
//   Parameters: WIDTH (8..16), BLANK_LZ (1 = blank leading zeros).
module display_formatter
    import display_formatter_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    display_formatter_if.slave   bus
);

    FormatterState       state;
    FormatterState       nextState;
    logic                accept;
    logic                busyInt;
    logic                fmtEdge;
    logic                negIn;
    logic [WIDTH-1:0]    magIn;
    logic                negReg;
    logic                coreDone;
    logic [BCD_BITS-1:0] coreBcd;
    logic [3:0]          d0, d1, d2, d3, d4;
    logic                overflow;
    logic [0:7]          signSeg;
    logic [0:7]          fmt0, fmt1, fmt2, fmt3;
    logic [0:7]          oct0Reg, oct1Reg, oct2Reg, oct3Reg;
    logic                doneReg;

    // Sign and magnitude of the incoming value. The magnitude is taken as an
    // unsigned WIDTH-bit number so the most negative input becomes 2^(WIDTH-1)
    // instead of wrapping back to itself.
    always_comb begin
        negIn = bus.Value[WIDTH-1];
        magIn = negIn ? (~bus.Value + WIDTH'(1)) : bus.Value;
    end

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. FMT also accepts Load, which lets a held Load restart
    // immediately and gives a steady one-result-per-(WIDTH+1)-cycles cadence.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = bus.Load ? CONV : IDLE;
            CONV:    nextState = coreDone ? FMT : CONV;
            FMT:     nextState = bus.Load ? CONV : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output decode: Busy covers only the shifting phase; a request is taken
    // whenever the converter is not busy.
    always_comb begin
        busyInt = (state == CONV);
        accept  = bus.Load && (state != CONV);
        fmtEdge = (state == FMT);
    end

    // The sign is captured with the request so later Value changes cannot
    // affect the conversion in flight.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            negReg <= 1'b0;
        end else if (accept) begin
            negReg <= negIn;
        end
    end

    bin2bcd_seq #(.WIDTH(WIDTH)) u_bin2bcd (
        .Clock (Clock),
        .Reset (Reset),
        .Start (accept),
        .Mag   (magIn),
        .Done  (coreDone),
        .Bcd   (coreBcd)
    );

    // Formatting from the finished BCD digits. Overflow is judged on the
    // digits themselves: a nonzero ten-thousands digit means above 9999, and
    // for negatives a nonzero thousands digit too means there is no room for
    // the sign. With blanking, the sign sits just left of the leading digit.
    always_comb begin
        d0       = coreBcd[3:0];
        d1       = coreBcd[7:4];
        d2       = coreBcd[11:8];
        d3       = coreBcd[15:12];
        d4       = coreBcd[19:16];
        overflow = (!negReg && (d4 != 4'd0)) ||
                   (negReg && ((d4 != 4'd0) || (d3 != 4'd0)));
        signSeg  = negReg ? SEG_MINUS : SEG_BLANK;
        fmt0     = SEG_BLANK;
        fmt1     = SEG_BLANK;
        fmt2     = SEG_BLANK;
        fmt3     = SEG_BLANK;
        if (overflow) begin
            fmt1 = SEG_E;
            fmt2 = SEG_R;
            fmt3 = SEG_R;
        end else if (BLANK_LZ) begin
            fmt3 = segOf(d0);
            if (d3 != 4'd0) begin
                fmt0 = segOf(d3);
                fmt1 = segOf(d2);
                fmt2 = segOf(d1);
            end else if (d2 != 4'd0) begin
                fmt0 = signSeg;
                fmt1 = segOf(d2);
                fmt2 = segOf(d1);
            end else if (d1 != 4'd0) begin
                fmt1 = signSeg;
                fmt2 = segOf(d1);
            end else begin
                fmt2 = signSeg;
            end
        end else begin
            fmt0 = negReg ? SEG_MINUS : segOf(d3);
            fmt1 = segOf(d2);
            fmt2 = segOf(d1);
            fmt3 = segOf(d0);
        end
    end

    // Display registers change only on the FMT edge, together with the Done
    // pulse, so the scanner never sees a half-finished conversion.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oct0Reg <= SEG_BLANK;
            oct1Reg <= SEG_BLANK;
            oct2Reg <= SEG_BLANK;
            oct3Reg <= SEG_BLANK;
            doneReg <= 1'b0;
        end else begin
            doneReg <= fmtEdge;
            if (fmtEdge) begin
                oct0Reg <= fmt0;
                oct1Reg <= fmt1;
                oct2Reg <= fmt2;
                oct3Reg <= fmt3;
            end
        end
    end

    assign bus.Busy = busyInt;
    assign bus.Done = doneReg;
    assign bus.oct0 = oct0Reg;
    assign bus.oct1 = oct1Reg;
    assign bus.oct2 = oct2Reg;
    assign bus.oct3 = oct3Reg;

endmodule

// File: tb/tb_display_formatter.sv
// tb_display_formatter
//   Directed bench for display_formatter: one instance with leading-zero
//   blanking and one without, sharing clock and reset. Expected patterns are
//   hand-encoded as {oct0,oct1,oct2,oct3} words.
module tb_display_formatter;

    // Hand-encoded expected displays.
    localparam logic [31:0] EXP_BLANK  = 32'h00000000;
    localparam logic [31:0] EXP_1234   = 32'h60DAF266;
    localparam logic [31:0] EXP_NEG5   = 32'h000002B6;
    localparam logic [31:0] EXP_ZERO   = 32'h000000FC;
    localparam logic [31:0] EXP_NEG999 = 32'h02F6F6F6;
    localparam logic [31:0] EXP_NEG99  = 32'h0002F6F6;
    localparam logic [31:0] EXP_ERR    = 32'h009E0A0A;
    localparam logic [31:0] EXP_42     = 32'h000066DA;
    localparam logic [31:0] EXP_9999   = 32'hF6F6F6F6;
    localparam logic [31:0] EXP_NEG7NZ = 32'h02FCFCE0;
    localparam logic [31:0] EXP_42NZ   = 32'hFCFC66DA;

    logic clock;
    logic reset;
    int   checkCount;
    int   errorCount;

    display_formatter_if #(.WIDTH(16)) bus  ();
    display_formatter_if #(.WIDTH(16)) bus2 ();

    display_formatter #(.WIDTH(16), .BLANK_LZ(1'b1)) dut (
        .Clock (clock),
        .Reset (reset),
        .bus   (bus.slave)
    );

    display_formatter #(.WIDTH(16), .BLANK_LZ(1'b0)) dutNoBlank (
        .Clock (clock),
        .Reset (reset),
        .bus   (bus2.slave)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] shown(input bit alt);
        if (alt) begin
            return {bus2.oct0, bus2.oct1, bus2.oct2, bus2.oct3};
        end
        return {bus.oct0, bus.oct1, bus.oct2, bus.oct3};
    endfunction

    // Issue one Load pulse and follow the conversion: samples on the falling
    // edge after accept edge N (k = 0) and after every later edge N+k.
    task automatic applyStimulus(input bit alt, input logic [15:0] v,
                                 output int doneEdge, output int busyCount);
        @(negedge clock);
        if (alt) begin bus2.Value = v; bus2.Load = 1'b1; end
        else     begin bus.Value  = v; bus.Load  = 1'b1; end
        @(posedge clock);
        #1;
        bus.Load  = 1'b0;
        bus2.Load = 1'b0;
        doneEdge  = -1;
        busyCount = 0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clock);
            if (alt ? bus2.Busy : bus.Busy) busyCount++;
            if (alt ? bus2.Done : bus.Done) begin
                doneEdge = k;
                break;
            end
        end
    endtask

    task automatic convertAndCheck(input string tag, input bit alt,
                                   input logic [15:0] v, input logic [31:0] expected);
        int doneEdge;
        int busyCount;
        applyStimulus(alt, v, doneEdge, busyCount);
        checkOutput({tag, "Latency"}, doneEdge, 17);
        checkOutput({tag, "Display"}, shown(alt), expected);
    endtask

    initial begin
        int doneEdge;
        int busyCount;
        int changed;
        int lastDone;
        int doneCount;
        int strayDone;

        checkCount = 0;
        errorCount = 0;
        reset      = 1'b0;
        bus.Value  = '0;
        bus.Load   = 1'b0;
        bus2.Value = '0;
        bus2.Load  = 1'b0;

        // Reset state.
        repeat (3) @(negedge clock);
        checkOutput("resetBusy", bus.Busy, 1'b0);
        checkOutput("resetDone", bus.Done, 1'b0);
        checkOutput("resetDisplay", shown(1'b0), EXP_BLANK);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // T2: basic conversion, latency and Busy length.
        applyStimulus(1'b0, 16'd1234, doneEdge, busyCount);
        checkOutput("t2Latency", doneEdge, 17);
        checkOutput("t2BusyCycles", busyCount, 16);
        checkOutput("t2Busy", bus.Busy, 1'b0);
        checkOutput("t2Display", shown(1'b0), EXP_1234);
        @(negedge clock);
        checkOutput("t2DonePulse", bus.Done, 1'b0);

        // T1: reset in the middle of a conversion.
        @(negedge clock);
        bus.Value = 16'd1234;
        bus.Load  = 1'b1;
        @(posedge clock);
        #1 bus.Load = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("t1BusyBefore", bus.Busy, 1'b1);
        reset = 1'b0;
        #1;
        checkOutput("t1Busy", bus.Busy, 1'b0);
        checkOutput("t1Display", shown(1'b0), EXP_BLANK);
        @(negedge clock);
        reset = 1'b1;
        strayDone = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clock);
            if (bus.Done || bus.Busy) strayDone++;
        end
        checkOutput("t1NoDone", strayDone, 0);

        // T3: signs, zero and blanking.
        convertAndCheck("t3Neg5", 1'b0, -16'sd5, EXP_NEG5);
        convertAndCheck("t3Zero", 1'b0, 16'd0, EXP_ZERO);
        convertAndCheck("t3Neg999", 1'b0, -16'sd999, EXP_NEG999);
        convertAndCheck("t3Neg99", 1'b0, -16'sd99, EXP_NEG99);

        // T4: overflow cases.
        convertAndCheck("t4Pos10000", 1'b0, 16'd10000, EXP_ERR);
        convertAndCheck("t4Neg1000", 1'b0, -16'sd1000, EXP_ERR);
        convertAndCheck("t4Neg32768", 1'b0, 16'h8000, EXP_ERR);

        // T5: Load during Busy is dropped and the display holds until Done.
        @(negedge clock);
        bus.Value = 16'd42;
        bus.Load  = 1'b1;
        @(posedge clock);
        #1 bus.Load = 1'b0;
        doneEdge = -1;
        changed  = 0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clock);
            if (bus.Done) begin
                doneEdge = k;
                break;
            end
            if (shown(1'b0) !== EXP_ERR) changed++;
            if (k == 2) begin
                bus.Value = 16'd77;
                bus.Load  = 1'b1;
            end
            if (k == 3) bus.Load = 1'b0;
        end
        checkOutput("t5Latency", doneEdge, 17);
        checkOutput("t5Hold", changed, 0);
        checkOutput("t5Display", shown(1'b0), EXP_42);
        strayDone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (bus.Done || bus.Busy) strayDone++;
        end
        checkOutput("t5NoQueue", strayDone, 0);

        // T6: Load held high re-converts every WIDTH+1 cycles.
        @(negedge clock);
        bus.Value = 16'd9999;
        bus.Load  = 1'b1;
        @(posedge clock);
        lastDone  = -1;
        doneCount = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (bus.Done) begin
                doneCount++;
                checkOutput("t6Display", shown(1'b0), EXP_9999);
                checkOutput("t6Period", k - lastDone, (lastDone < 0) ? k + 1 : 17);
                if (lastDone < 0) checkOutput("t6First", k, 17);
                lastDone = k;
            end
        end
        checkOutput("t6Count", doneCount, 3);
        bus.Load = 1'b0;
        repeat (25) @(negedge clock);
        checkOutput("t6Steady", shown(1'b0), EXP_9999);

        // T6: no leading-zero blanking.
        convertAndCheck("t6NzNeg7", 1'b1, -16'sd7, EXP_NEG7NZ);
        convertAndCheck("t6Nz42", 1'b1, 16'd42, EXP_42NZ);
        convertAndCheck("t6NzErr", 1'b1, -16'sd1000, EXP_ERR);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
